nor_chain_tdc: RTL and testbench

Parametrised NOR2_X1 delay chain wrapped in a self-timed, tapped-delay-line measurement engine. It launches an edge of selectable polarity into an N-stage chain of NOR2_X1 cells (A2 tied low) and captures every stage output one clock later. It then decodes the thermometer code to a stage count and accumulates 2^AVG_LOG launches. The block sits beside the existing delay-evaluation chains and turns per-stage propagation delay into a digital reading for IDM characterisation runs.

---
 rtl/nor_tdc_pkg.sv | 28 ++
 rtl/nor_delay_line.sv | 32 +++
 rtl/nor_chain_tdc.sv | 173 +++++++++++++++++
 tb/tb_nor_chain_tdc.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nor_tdc_pkg.sv
// nor_tdc_pkg
//   Shared types and helpers for the NOR-chain TDC.
//   state_t  : measurement FSM states
//   cnt_w()  : width of a counter that must hold values 0..n (min 1 bit)
//   norm_tap : turns a raw chain tap into "launched edge has passed" (1) / "not yet" (0)
package nor_tdc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_LAUNCH,
    S_CAPTURE,
    S_DECODE,
    S_DONE
  } state_t;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

  // Every NOR stage inverts, so even-index taps sit at ~din and odd-index
  // taps at din.  XOR with polarity and the stage parity maps both launch
  // polarities onto the same thermometer sense.
  function automatic logic norm_tap(input logic tap, input logic pol, input int idx);
    return tap ^ pol ^ ~idx[0];
  endfunction

endpackage

// File: rtl/nor_delay_line.sv
// nor_delay_line
//   STAGES inverting NOR2_X1 stages in series, second input tied low.
//   din            : chain input (driven by the launch flop)
//   taps[STAGES-1:0] : output of every stage, taps[0] nearest din
//   Purely combinational and unreset.  Each stage is written as a two-input
//   NOR so synthesis maps it onto NOR2_X1; it is kept in its own module so
//   the cells can be preserved (dont_touch) and the taps can be overridden
//   in simulation.
module nor_delay_line #(
  parameter int STAGES = 26
) (
  input  logic              din,
  output logic [STAGES-1:0] taps
);

  localparam logic A2_TIE = 1'b0;

  // Each stage reads its predecessor's own net rather than taps[i-1], so
  // the chain is not a vector that feeds back into itself.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic a1;
    logic y;
    if (i == 0) begin : g_first
      assign a1 = din;
    end else begin : g_next
      assign a1 = g_stage[i-1].y;
    end
    assign y       = ~(a1 | A2_TIE);
    assign taps[i] = y;
  end

endmodule

// File: rtl/nor_chain_tdc.sv
// nor_chain_tdc
//   Tapped-delay-line TDC around a NOR2_X1 chain.  Launches an edge,
//   captures all taps one clock later, decodes the thermometer code and
//   accumulates 2^AVG_LOG launches per measurement.
//   clk, rst_n : clock, async active-low reset
//   start      : measurement request (accepted in IDLE only)
//   polarity   : 0 rising launch, 1 falling launch (latched on start)
//   busy       : measurement in progress
//   done       : one-cycle pulse, sum/avg/ovf/bubble valid
//   sum, avg   : accumulated codes and truncated average
//   ovf        : some launch ran through the whole chain
//   bubble     : some launch produced a non-monotonic thermometer code
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | waiting for start; outputs hold last result
//   S_SETTLE  | chain input at idle level, SETTLE_CYC cycles
//   S_LAUNCH  | chain input at launched level; taps sampled at cycle end
//   S_CAPTURE | second capture rank (metastability)
//   S_DECODE  | decode code, accumulate, next launch or finish
//   S_DONE    | done pulse
module nor_chain_tdc
  import nor_tdc_pkg::*;
#(
  parameter int STAGES     = 26,
  parameter int TAP_W      = $clog2(STAGES + 1),
  parameter int AVG_LOG    = 3,
  parameter int SETTLE_CYC = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     polarity,
  output logic                     busy,
  output logic                     done,
  output logic [TAP_W+AVG_LOG-1:0] sum,
  output logic [TAP_W-1:0]         avg,
  output logic                     ovf,
  output logic                     bubble
);

  localparam int SUM_W  = TAP_W + AVG_LOG;
  localparam int SCNT_W = cnt_w(SETTLE_CYC - 1);
  localparam int LCNT_W = cnt_w(2 ** AVG_LOG - 1);

  localparam logic [SCNT_W-1:0] SETTLE_LOAD = SCNT_W'(SETTLE_CYC - 1);
  localparam logic [LCNT_W-1:0] LAST_LAUNCH = LCNT_W'(2 ** AVG_LOG - 1);
  localparam logic [TAP_W-1:0]  FULL_CODE   = TAP_W'(STAGES);

  state_t              state;
  logic                pol_q;
  logic                launch;
  logic [SCNT_W-1:0]   settle_cnt;
  logic [LCNT_W-1:0]   launch_cnt;
  logic [STAGES-1:0]   taps;
  logic [STAGES-1:0]   cap_q;
  logic [STAGES-1:0]   cap_s;
  logic [STAGES-1:0]   norm;
  logic [TAP_W-1:0]    dec_code;
  logic                dec_bubble;
  logic                dec_ovf;
  logic                seen_zero;
  logic [SUM_W-1:0]    sum_next;

  nor_delay_line #(
    .STAGES (STAGES)
  ) u_line (
    .din  (launch),
    .taps (taps)
  );

  for (genvar i = 0; i < STAGES; i++) begin : g_norm
    assign norm[i] = norm_tap(cap_s[i], pol_q, i);
  end

  // Code is the run of ones starting at stage 0; any one after the first
  // zero is a bubble and does not count.
  always_comb begin
    dec_code   = '0;
    dec_bubble = 1'b0;
    seen_zero  = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      if (!norm[i]) begin
        seen_zero = 1'b1;
      end else if (seen_zero) begin
        dec_bubble = 1'b1;
      end else begin
        dec_code = dec_code + 1'b1;
      end
    end
  end

  assign dec_ovf  = (dec_code == FULL_CODE);
  assign sum_next = sum + SUM_W'(dec_code);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pol_q      <= 1'b0;
      launch     <= 1'b0;
      settle_cnt <= '0;
      launch_cnt <= '0;
      cap_q      <= '0;
      cap_s      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sum        <= '0;
      avg        <= '0;
      ovf        <= 1'b0;
      bubble     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pol_q      <= polarity;
            launch     <= polarity;
            settle_cnt <= SETTLE_LOAD;
            launch_cnt <= '0;
            sum        <= '0;
            avg        <= '0;
            ovf        <= 1'b0;
            bubble     <= 1'b0;
            busy       <= 1'b1;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            launch <= ~pol_q;
            state  <= S_LAUNCH;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_LAUNCH: begin
          // Taps are sampled exactly one period after the launch edge; the
          // input returns to idle on the same edge so the chain has the
          // rest of the launch slot to recover.
          cap_q  <= taps;
          launch <= pol_q;
          state  <= S_CAPTURE;
        end
        S_CAPTURE: begin
          cap_s <= cap_q;
          state <= S_DECODE;
        end
        S_DECODE: begin
          sum    <= sum_next;
          ovf    <= ovf | dec_ovf;
          bubble <= bubble | dec_bubble;
          if (launch_cnt != LAST_LAUNCH) begin
            launch_cnt <= launch_cnt + 1'b1;
            settle_cnt <= SETTLE_LOAD;
            state      <= S_SETTLE;
          end else begin
            avg   <= TAP_W'(sum_next >> AVG_LOG);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nor_chain_tdc.sv
// tb_nor_chain_tdc
//   Drives the TDC with a behavioural transport-delay model of the chain
//   (stage j toggles j*stage_delay after the chain input changes) forced
//   onto the DUT taps, and compares each measurement against codes derived
//   from the clock period and stage delay.
module tb_nor_chain_tdc;

  localparam int STAGES     = 26;
  localparam int TAP_W      = $clog2(STAGES + 1);
  localparam int AVG_LOG    = 3;
  localparam int SETTLE_CYC = 4;
  localparam int LAUNCHES   = 1 << AVG_LOG;
  localparam int LATENCY    = 1 + LAUNCHES * (SETTLE_CYC + 3);
  localparam int CLK_P      = 40000;

  logic                     clk;
  logic                     rst_n;
  logic                     start;
  logic                     polarity;
  logic                     busy;
  logic                     done;
  logic [TAP_W+AVG_LOG-1:0] sum;
  logic [TAP_W-1:0]         avg;
  logic                     ovf;
  logic                     bubble;

  int n_chk;
  int n_bad;

  int                dly_ps;
  logic              cur_pol;
  int                l_idx;
  int                bub_abs;
  logic              inject;
  logic [STAGES-1:0] model_taps;
  logic [STAGES-1:0] bubble_raw;

  nor_chain_tdc #(
    .STAGES     (STAGES),
    .TAP_W      (TAP_W),
    .AVG_LOG    (AVG_LOG),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .polarity (polarity),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .avg      (avg),
    .ovf      (ovf),
    .bubble   (bubble)
  );

  initial clk = 1'b0;
  always #(CLK_P / 2) clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Transport-delay inverter chain: every change of the chain input ripples
  // through, stage j (0-based) settling (j+1)*d after the input change.
  task automatic spawn_edge(input logic v, input int d);
    for (int j = 0; j < STAGES; j++) begin
      automatic int jj = j;
      fork
        begin
          #((jj + 1) * d);
          model_taps[jj] = (jj % 2 == 0) ? ~v : v;
        end
      join_none
    end
  endtask

  task automatic pulse_inject();
    fork
      begin
        inject = 1'b1;
        #(CLK_P + 1000);
        inject = 1'b0;
      end
    join_none
  endtask

  always @(dut.launch) begin
    spawn_edge(dut.launch, dly_ps);
    if (dut.launch == ~cur_pol && busy) begin
      if (l_idx == bub_abs) pulse_inject();
      l_idx = l_idx + 1;
    end
  end

  always @(model_taps or inject) begin
    if (inject) force dut.taps = bubble_raw;
    else        force dut.taps = model_taps;
  end

  task automatic run_meas(input logic pol, input int d, input int bub);
    int   exp_sum;
    int   c;
    int   n;
    logic exp_ovf;
    logic exp_bub;
    logic got_done;
    logic busy_ok;
    exp_sum = 0;
    exp_ovf = 1'b0;
    exp_bub = 1'b0;
    for (int k = 0; k < LAUNCHES; k++) begin
      if (k == bub) begin
        c = 3;
        exp_bub = 1'b1;
      end else begin
        c = CLK_P / d;
        if (c > STAGES) c = STAGES;
      end
      exp_sum += c;
      if (c == STAGES) exp_ovf = 1'b1;
    end
    // Normalised pattern 1110100...0 expressed as raw tap levels.
    for (int i = 0; i < STAGES; i++)
      bubble_raw[i] = ((i < 3) || (i == 4)) ^ pol ^ (i % 2 == 0);
    dly_ps  = d;
    bub_abs = (bub < 0) ? -1 : l_idx + bub;
    @(negedge clk);
    polarity = pol;
    cur_pol  = pol;
    start    = 1'b1;
    n        = 0;
    got_done = 1'b0;
    busy_ok  = 1'b1;
    while (!got_done && n < 200) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (done) got_done = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    check_val("latency", n, LATENCY);
    check_val("busy_run", busy_ok, 1);
    check_val("sum", sum, exp_sum);
    check_val("avg", avg, exp_sum >> AVG_LOG);
    check_val("ovf", ovf, exp_ovf);
    check_val("bubble", bubble, exp_bub);
    @(posedge clk);
    #1;
    check_val("done_width", done, 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("sum_hold", sum, exp_sum);
  endtask

  initial begin
    int d;
    int b;
    logic p;
    int n;
    int dcount;
    int first_done;
    int second_done;
    int dbl;
    int drop;
    logic prev_done;
    logic prev_busy;

    n_chk    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    polarity = 1'b0;
    cur_pol  = 1'b0;
    dly_ps   = 3990;
    l_idx    = 0;
    bub_abs  = -1;
    inject   = 1'b0;
    bubble_raw = '0;
    for (int i = 0; i < STAGES; i++) model_taps[i] = (i % 2 == 0);
    force dut.taps = model_taps;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_sum", sum, 0);
    check_val("rst_avg", avg, 0);
    check_val("rst_ovf", ovf, 0);
    check_val("rst_bubble", bubble, 0);
    check_val("rst_cap_q", dut.cap_q, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);

    // Stage delay just under a tenth of the period: ten stages per launch.
    run_meas(1'b0, 3990, -1);
    run_meas(1'b1, 3990, -1);
    // Stage delay ~period/40: edge runs off the end of the chain.
    run_meas(1'b0, 999, -1);
    // Injected bubble on launch 2.
    run_meas(1'b0, 3990, 2);
    run_meas(1'b1, 3990, 5);

    for (int r = 0; r < 6; r++) begin
      d = $urandom_range(5900, 1000);
      while (CLK_P % d == 0) d = $urandom_range(5900, 1000);
      p = 1'($urandom_range(1, 0));
      b = ($urandom_range(1, 0) == 0) ? -1 : int'($urandom_range(7, 0));
      run_meas(p, d, b);
    end

    // Asynchronous reset while decoding the third launch.
    dly_ps  = 3990;
    bub_abs = -1;
    @(negedge clk);
    polarity = 1'b0;
    cur_pol  = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #5000;
    check_val("pre_rst_busy", busy, 1);
    check_val("pre_rst_sum", sum, 20);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_sum", sum, 0);
    check_val("mid_rst_state", dut.state, nor_tdc_pkg::S_IDLE);
    check_val("mid_rst_launch", dut.launch, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check_val("no_done_after_rst", dcount, 0);
    run_meas(1'b0, 3990, -1);

    // start held high: one measurement per IDLE visit (done, DONE, IDLE, accept).
    dly_ps  = 3990;
    bub_abs = -1;
    @(negedge clk);
    polarity = 1'b1;
    cur_pol  = 1'b1;
    start    = 1'b1;
    n = 0;
    dcount = 0;
    first_done = 0;
    second_done = 0;
    dbl = 0;
    drop = 0;
    prev_done = 1'b0;
    prev_busy = 1'b0;
    while ((n < 100) || (second_done == 0 && n < 300)) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 100) start = 1'b0;
      if (done) begin
        if (n <= 100) dcount++;
        if (first_done == 0) first_done = n;
        else if (second_done == 0) second_done = n;
        if (prev_done) dbl++;
      end
      if (prev_busy && !busy && !done) drop++;
      prev_done = done;
      prev_busy = busy;
    end
    check_val("hold_done_cnt", dcount, 1);
    check_val("hold_first_done", first_done, LATENCY);
    check_val("hold_second_done", second_done, 2 * LATENCY + 1);
    check_val("hold_double_pulse", dbl, 0);
    check_val("hold_busy_drop", drop, 0);
    check_val("hold_sum", sum, 80);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
